// File: rtl/uart_rx.sv
// Oversampled UART receiver: start-glitch rejection, optional odd parity, framing check.
// Bit timing advances only on sample_tick; samples are taken at mid-bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_pin,
  input  logic                 parity_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_bit, par_next;
  logic                 frame_done;
  logic                 sync_1, rx_s;

  // Two-flop synchronizer, reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their old inputs on the
      // same edge; blocking here would collapse the chain into a single flop.
      sync_1 <= rx_pin;
      rx_s   <= sync_1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    par_next   = par_bit;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        if (sample_tick && !rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (cnt == HALF_LAST) begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = rx_s ? IDLE : DATA;  // high at mid-start means a glitch
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            cnt_next        = '0;
            shift_next[idx] = rx_s;
            if (idx == IDX_LAST) state_next = parity_enable ? PARITY : STOP;
            else                 idx_next   = idx + IDX_W'(1);
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            cnt_next   = '0;
            par_next   = rx_s;
            state_next = STOP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            cnt_next   = '0;
            frame_done = 1'b1;
            state_next = rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      WAIT_IDLE: begin
        if (sample_tick && rx_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      par_bit       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      par_bit  <= par_next;
      rx_valid <= frame_done;
      if (frame_done) begin
        rx_data       <= shift;
        // Odd parity: data bits plus parity bit must XOR to 1.
        parity_error  <= parity_enable & ~(^shift ^ par_bit);
        framing_error <= ~rx_s;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a line-level frame model pushes expected
// words, an independent monitor pops and compares on every rx_valid pulse.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx_pin;
  logic       parity_enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_valid = 0;
  int   n_sent  = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .rx_pin       (rx_pin),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the line at level v for a number of sample ticks.
  task automatic hold(input logic v, input int ticks);
    rx_pin = v;
    repeat (ticks * TICK_DIV) @(negedge clk);
  endtask

  // One complete frame on the line; the expected receiver response follows from the frame rules.
  task automatic send_frame(input logic [7:0] data, input logic par_good, input logic stop);
    exp_t e;
    logic pbit;
    pbit   = par_good ? ~^data : ^data;
    e.data = data;
    e.perr = parity_enable && ((^data ^ pbit) != 1'b1);
    e.ferr = (stop == 1'b0);
    e.busy = (stop == 1'b0);
    sb.push_back(e);
    n_sent++;
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(data[i], OS);
    if (parity_enable) hold(pbit, OS);
    hold(stop, OS);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_parity_error"}, 32'(parity_error), 32'h0);
    check({tag, "_framing_error"}, 32'(framing_error), 32'h0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'h0);
  endtask

  // Monitor: every rx_valid pulse must match the oldest pending frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        n_valid++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: rx_data=0x%0h with no frame pending", rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("parity_error", 32'(parity_error), 32'(e.perr));
          check("framing_error", 32'(framing_error), 32'(e.ferr));
          check("rx_busy_at_valid", 32'(rx_busy), 32'(e.busy));
        end
      end
    end
  end

  initial begin
    #800us;
    n_cmp++;
    n_err++;
    $display("FAIL timeout: bench did not finish, %0d frames still pending", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [7:0] d;
    reset         = 1'b1;
    rx_pin        = 1'b1;
    parity_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    hold(1'b1, 2 * OS);

    // Plain frame, parity off.
    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 2 * OS);
    check("busy_after_a5", 32'(rx_busy), 32'h0);

    // Odd parity, good then bad.
    parity_enable = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1);
    hold(1'b1, OS);
    send_frame(8'h03, 1'b0, 1'b1);
    hold(1'b1, OS);
    parity_enable = 1'b0;

    // Short start glitch must be ignored.
    hold(1'b0, 4);
    hold(1'b1, 2 * OS);
    check("busy_after_glitch", 32'(rx_busy), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, OS);

    // Framing error followed by a long break.
    send_frame(8'h55, 1'b1, 1'b0);
    hold(1'b0, 29 * OS);
    check("busy_during_break", 32'(rx_busy), 32'h1);
    hold(1'b1, 2 * OS);
    check("busy_after_break", 32'(rx_busy), 32'h0);
    send_frame(8'h81, 1'b1, 1'b1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b1, 1'b1);
    hold(1'b1, OS);

    // Reset in the middle of data bit 3 abandons the frame.
    d = 8'h96;
    hold(1'b0, OS);
    for (int i = 0; i < 3; i++) hold(d[i], OS);
    hold(d[3], OS / 2);
    reset  = 1'b1;
    rx_pin = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    reset = 1'b0;
    hold(1'b1, 3 * OS);
    send_frame(8'hC3, 1'b1, 1'b1);

    // Randomized frames with random gaps, parity mode and parity corruption.
    for (int n = 0; n < 16; n++) begin
      rx_pin = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      parity_enable = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), 1'b1);
    end

    hold(1'b1, 3 * OS);
    check("frames_pending", 32'(sb.size()), 32'h0);
    check("valid_count", 32'(n_valid), 32'(n_sent));
    check("busy_at_end", 32'(rx_busy), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
